// File: rtl/enemy_attack_ctrl.sv
// Per-enemy attack initiator: range test, windup/strike/cooldown/stagger FSM,
// strike pulse for the damage logic, and facing/state for the sprite renderer.
module enemy_attack_ctrl #(
    parameter int unsigned id              = 0,
    parameter logic [8:0]  ATTACK_RANGE    = 9'd8,
    parameter logic [8:0]  ENEMY_WIDTH     = 9'd26,
    parameter logic [8:0]  ENEMY_HEIGHT    = 9'd26,
    parameter logic [8:0]  PLAYER_SIZE     = 9'd26,
    parameter logic [7:0]  WINDUP_FRAMES   = 8'd8,
    parameter logic [7:0]  COOLDOWN_FRAMES = 8'd30,
    parameter logic [7:0]  STAGGER_FRAMES  = 8'd12
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       game_frame_clk_rising_edge,
    input  logic [8:0] Player_X,
    input  logic [8:0] Player_Y,
    input  logic [8:0] Enemy_X,
    input  logic [8:0] Enemy_Y,
    input  logic       Enemy_Alive,
    input  logic       Enemy_Is_Attacked,
    input  logic       Godmode_On,
    output logic       Enemy_Attack_On,
    output logic [2:0] Enemy_Attack_State,
    output logic [1:0] Enemy_Facing,
    output logic [7:0] Strike_Count
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WINDUP   = 3'd1,
        S_STRIKE   = 3'd2,
        S_COOLDOWN = 3'd3,
        S_STAGGER  = 3'd4
    } state_e;

    // Low id bits stretch the windup so neighbouring enemies don't strike in lockstep.
    localparam logic [7:0] WIND_LAST = WINDUP_FRAMES + 8'(id % 4) - 8'd1;
    localparam logic [7:0] COOL_LAST = COOLDOWN_FRAMES - 8'd1;
    localparam logic [7:0] STAG_LAST = STAGGER_FRAMES - 8'd1;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] face_q, face_d;
    logic [7:0] sc_q, sc_d;

    logic       tick;
    logic       in_range;
    logic signed [9:0] dx, dy;
    logic [9:0] adx, ady;
    logic [1:0] face_calc;

    assign tick = game_frame_clk_rising_edge;

    assign in_range =
        ({1'b0, Enemy_X} + {1'b0, ENEMY_WIDTH} + {1'b0, ATTACK_RANGE} >= {1'b0, Player_X}) &&
        ({1'b0, Player_X} + {1'b0, PLAYER_SIZE} + {1'b0, ATTACK_RANGE} >= {1'b0, Enemy_X}) &&
        ({1'b0, Enemy_Y} + {1'b0, ENEMY_HEIGHT} + {1'b0, ATTACK_RANGE} >= {1'b0, Player_Y}) &&
        ({1'b0, Player_Y} + {1'b0, PLAYER_SIZE} + {1'b0, ATTACK_RANGE} >= {1'b0, Enemy_Y});

    assign dx  = $signed({1'b0, Player_X}) - $signed({1'b0, Enemy_X});
    assign dy  = $signed({1'b0, Player_Y}) - $signed({1'b0, Enemy_Y});
    assign adx = dx[9] ? 10'(-dx) : 10'(dx);
    assign ady = dy[9] ? 10'(-dy) : 10'(dy);

    // Horizontal wins ties, so a coincident player faces right.
    always_comb begin
        face_calc = 2'd3;
        if (adx >= ady)               face_calc = dx[9] ? 2'd1 : 2'd3;
        else if (!dy[9] && dy != '0)  face_calc = 2'd0;
        else                          face_calc = 2'd2;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            face_q  <= '0;
            sc_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            face_q  <= face_d;
            sc_q    <= sc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        face_d  = face_q;
        sc_d    = sc_q;
        if (tick && (state_q == S_IDLE || state_q == S_WINDUP))
            face_d = face_calc;
        if (!Enemy_Alive) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (Enemy_Is_Attacked) state_d = S_STAGGER;
                    else if (in_range)     state_d = S_WINDUP;
                end
                S_WINDUP: begin
                    if (Enemy_Is_Attacked) begin
                        state_d = S_STAGGER;
                        cnt_d   = '0;
                    end else if (!in_range) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == WIND_LAST) begin
                        state_d = S_STRIKE;
                        cnt_d   = '0;
                        sc_d    = sc_q + 8'd1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_STRIKE: begin
                    state_d = S_COOLDOWN;
                    cnt_d   = '0;
                end
                S_COOLDOWN: begin
                    if (cnt_q == COOL_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                S_STAGGER: begin
                    if (Enemy_Is_Attacked) begin
                        cnt_d = '0;
                    end else if (cnt_q == STAG_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Strike is decoded from registered state; godmode only masks the pulse.
    always_comb begin
        Enemy_Attack_On    = (state_q == S_STRIKE) && !Godmode_On;
        Enemy_Attack_State = state_q;
        Enemy_Facing       = face_q;
        Strike_Count       = sc_q;
    end

endmodule

// File: tb/tb_enemy_attack_ctrl.sv
// Random and directed bench for enemy_attack_ctrl; two instances (id 0 and 3)
// are tracked by a countdown-based behavioural model of the attack rules.
module tb_enemy_attack_ctrl;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       Reset, tick, alive, hit, god;
    logic [8:0] px, py, ex, ey;

    logic       atk  [2];
    logic [2:0] st   [2];
    logic [1:0] face [2];
    logic [7:0] sc   [2];

    enemy_attack_ctrl #(.id(0)) u_e0 (
        .Clk(Clk), .Reset(Reset), .game_frame_clk_rising_edge(tick),
        .Player_X(px), .Player_Y(py), .Enemy_X(ex), .Enemy_Y(ey),
        .Enemy_Alive(alive), .Enemy_Is_Attacked(hit), .Godmode_On(god),
        .Enemy_Attack_On(atk[0]), .Enemy_Attack_State(st[0]),
        .Enemy_Facing(face[0]), .Strike_Count(sc[0]));

    enemy_attack_ctrl #(.id(3)) u_e3 (
        .Clk(Clk), .Reset(Reset), .game_frame_clk_rising_edge(tick),
        .Player_X(px), .Player_Y(py), .Enemy_X(ex), .Enemy_Y(ey),
        .Enemy_Alive(alive), .Enemy_Is_Attacked(hit), .Godmode_On(god),
        .Enemy_Attack_On(atk[1]), .Enemy_Attack_State(st[1]),
        .Enemy_Facing(face[1]), .Strike_Count(sc[1]));

    localparam int IDLE = 0, WINDUP = 1, STRIKE = 2, COOLDOWN = 3, STAGGER = 4;
    localparam int COOL = 30, STAG = 12, REACH = 26 + 8;

    int checks = 0;
    int errors = 0;
    int m_st [2];
    int m_left [2];
    int m_face [2];
    int m_sc [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int windup(input int k);
        return (k == 0) ? 8 : 11;
    endfunction

    function automatic bit reach();
        int exi, eyi, pxi, pyi;
        exi = int'(ex); eyi = int'(ey); pxi = int'(px); pyi = int'(py);
        return (exi + REACH >= pxi) && (pxi + REACH >= exi) &&
               (eyi + REACH >= pyi) && (pyi + REACH >= eyi);
    endfunction

    function automatic int look();
        int dx, dy, adx, ady;
        dx = int'(px) - int'(ex);
        dy = int'(py) - int'(ey);
        adx = (dx < 0) ? -dx : dx;
        ady = (dy < 0) ? -dy : dy;
        if (adx >= ady) return (dx < 0) ? 1 : 3;
        return (dy > 0) ? 0 : 2;
    endfunction

    // Model: each timed phase keeps the number of further ticks it must wait.
    task automatic model(input int k, input bit tk);
        bit r;
        r = reach();
        if (tk && (m_st[k] == IDLE || m_st[k] == WINDUP)) m_face[k] = look();
        if (Reset) begin
            m_st[k] = IDLE; m_face[k] = 0; m_sc[k] = 0;
        end else if (!alive) begin
            m_st[k] = IDLE;
        end else if (tk) begin
            case (m_st[k])
                IDLE:
                    if (hit) begin m_st[k] = STAGGER; m_left[k] = STAG - 1; end
                    else if (r) begin m_st[k] = WINDUP; m_left[k] = windup(k) - 1; end
                WINDUP:
                    if (hit) begin m_st[k] = STAGGER; m_left[k] = STAG - 1; end
                    else if (!r) m_st[k] = IDLE;
                    else if (m_left[k] == 0) begin
                        m_st[k] = STRIKE; m_sc[k] = (m_sc[k] + 1) % 256;
                    end else m_left[k]--;
                STRIKE: begin m_st[k] = COOLDOWN; m_left[k] = COOL - 1; end
                COOLDOWN:
                    if (m_left[k] == 0) m_st[k] = IDLE;
                    else m_left[k]--;
                default:
                    if (hit) m_left[k] = STAG - 1;
                    else if (m_left[k] == 0) m_st[k] = IDLE;
                    else m_left[k]--;
            endcase
        end
    endtask

    task automatic step(input bit tk);
        tick = tk;
        for (int k = 0; k < 2; k++) model(k, tk);
        @(posedge Clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk(k == 0 ? "state0" : "state3", 32'(st[k]), 32'(m_st[k]));
            chk(k == 0 ? "atk0" : "atk3", 32'(atk[k]), 32'(m_st[k] == STRIKE && !god));
            chk(k == 0 ? "face0" : "face3", 32'(face[k]), 32'(m_face[k]));
            chk(k == 0 ? "scnt0" : "scnt3", 32'(sc[k]), 32'(m_sc[k]));
        end
        tick = 1'b0;
    endtask

    // n frames, each gap Clk long with the tick on the last Clk.
    task automatic frames(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < gap - 1; j++) step(1'b0);
            step(1'b1);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step(1'b0);
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; tick = 1'b0; alive = 1'b1; hit = 1'b0; god = 1'b0;
        ex = 9'd100; ey = 9'd100; px = 9'd130; py = 9'd100;
        for (int k = 0; k < 2; k++) begin
            m_st[k] = IDLE; m_left[k] = 0; m_face[k] = 0; m_sc[k] = 0;
        end
        step(1'b0);
        step(1'b0);
        chk("rst_state", 32'(st[0]), 0);
        chk("rst_atk", 32'(atk[0]), 0);
        chk("rst_face", 32'(face[0]), 0);
        chk("rst_scnt", 32'(sc[0]), 0);
        Reset = 1'b0;

        // strike cycle
        frames(1, 4);  chk("t1_windup", 32'(st[0]), WINDUP);
        frames(8, 4);  chk("t9_strike", 32'(st[0]), STRIKE);
        chk("t9_atk", 32'(atk[0]), 1);
        chk("t9_scnt", 32'(sc[0]), 1);
        chk("t9_id3_windup", 32'(st[1]), WINDUP);
        frames(1, 4);  chk("t10_cool", 32'(st[0]), COOLDOWN);
        frames(2, 4);  chk("t12_id3_strike", 32'(st[1]), STRIKE);
        frames(28, 4); chk("t40_idle", 32'(st[0]), IDLE);
        frames(1, 4);  chk("t41_windup", 32'(st[0]), WINDUP);
        frames(8, 4);  chk("t49_strike", 32'(st[0]), STRIKE);
        chk("face_right", 32'(face[0]), 3);

        // out of range
        do_reset();
        px = 9'd140;
        frames(100, 4);
        chk("oor_state", 32'(st[0]), IDLE);
        chk("oor_scnt", 32'(sc[0]), 0);

        // abort
        do_reset();
        px = 9'd130;
        frames(4, 4);
        px = 9'd200;
        frames(1, 4);
        chk("abort_state", 32'(st[0]), IDLE);
        chk("abort_scnt", 32'(sc[0]), 0);

        // stagger, restart, and hit ignored in cooldown
        do_reset();
        px = 9'd130;
        frames(3, 4);
        hit = 1'b1; frames(1, 4); hit = 1'b0;
        chk("t4_stagger", 32'(st[0]), STAGGER);
        frames(3, 4);
        hit = 1'b1; frames(1, 4); hit = 1'b0;
        frames(11, 4); chk("t19_stagger", 32'(st[0]), STAGGER);
        frames(1, 4);  chk("t20_idle", 32'(st[0]), IDLE);
        frames(1, 4);  chk("t21_windup", 32'(st[0]), WINDUP);
        frames(9, 4);  chk("t30_cool", 32'(st[0]), COOLDOWN);
        hit = 1'b1; frames(5, 4); hit = 1'b0;
        chk("cool_hit_ignored", 32'(st[0]), COOLDOWN);

        // godmode
        do_reset();
        god = 1'b1;
        frames(9, 4);
        chk("god_state", 32'(st[0]), STRIKE);
        chk("god_atk", 32'(atk[0]), 0);
        chk("god_scnt", 32'(sc[0]), 1);
        god = 1'b0;

        // kill right after strike entry
        do_reset();
        frames(9, 4);
        alive = 1'b0; step(1'b0); alive = 1'b1;
        chk("kill_state", 32'(st[0]), IDLE);
        chk("kill_atk", 32'(atk[0]), 0);

        // reset mid-cooldown
        do_reset();
        frames(15, 4);
        Reset = 1'b1; step(1'b0); Reset = 1'b0;
        chk("rst_cool_state", 32'(st[0]), IDLE);
        chk("rst_cool_scnt", 32'(sc[0]), 0);

        // Strike_Count wrap: 257 strikes with back-to-back ticks
        frames(257 * 40, 1);
        chk("wrap_scnt", 32'(sc[0]), 1);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                px = 9'($urandom_range(50, 180));
                py = 9'($urandom_range(50, 180));
            end
            if ($urandom_range(0, 99) == 0) begin
                ex = 9'($urandom_range(80, 120));
                ey = 9'($urandom_range(80, 120));
            end
            hit   = ($urandom_range(0, 19) == 0);
            alive = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 29) == 0) god = ~god;
            Reset = ($urandom_range(0, 799) == 0);
            step($urandom_range(0, 2) == 0);
        end
        Reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
